// File: rtl/seg_scan_mux_if.sv
// ============================================================================
// Module      : seg_scan_mux_if
// Description : Interface bundling the value/load/enable inputs and the
//               scanned display outputs of seg_scan_mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int c_idx_w = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              number;
    logic [NUM_DIGITS-1:0]   anode;
    logic [c_idx_w-1:0]      digit_idx;
    logic                    frame_tick;

    modport master (
        output value, load, digit_en,
        input  number, anode, digit_idx, frame_tick
    );

    modport slave (
        input  value, load, digit_en,
        output number, anode, digit_idx, frame_tick
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexed hex display scanner with frame-aligned
//               double buffering and per-slot dead-time blanking.
//               Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seg_scan_mux_if.slave     bus
);
    localparam int c_idx_w = $clog2(NUM_DIGITS);
    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam int c_val_w = 4 * NUM_DIGITS;

    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_blank    = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_digit0   = NUM_DIGITS'(1);

    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [c_idx_w-1:0]    idx_q, idx_d;
    logic [c_val_w-1:0]    pending_q, pending_d;
    logic [c_val_w-1:0]    active_q, active_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            number_q, number_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  w_slot_end;
    logic                  w_frame_wrap;
    logic [NUM_DIGITS-1:0] w_lzb_dark;

    assign w_slot_end   = (cnt_q == c_cnt_last);
    assign w_frame_wrap = w_slot_end && (idx_q == c_idx_last);

`ifdef SEG_SCAN_LZB_EN
    // Walk down from the top nibble; a digit is dark while everything at or
    // above it is zero. Digit 0 is left out so a zero value still shows "0".
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_lzb_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (active_d[4*i +: 4] == 4'h0);
            w_lzb_dark[i] = zero_above;
        end
    end
`else
    assign w_lzb_dark = '0;
`endif

    always_comb begin
        cnt_d        = w_slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        pending_d    = pending_q;
        active_d     = active_q;
        pend_valid_d = pend_valid_q;

        if (w_slot_end) begin
            idx_d = w_frame_wrap ? '0 : idx_q + 1'b1;
        end

        if (bus.load) begin
            pending_d    = bus.value;
            pend_valid_d = 1'b1;
        end

        // A load landing on the boundary edge bypasses the pending buffer.
        if (w_frame_wrap) begin
            if (bus.load) begin
                active_d = bus.value;
            end else if (pend_valid_q) begin
                active_d = pending_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Outputs are computed from next-state so they line up with digit_idx.
    always_comb begin
        number_d     = active_d[{idx_d, 2'b00} +: 4];
        frame_tick_d = w_frame_wrap;
        if ((cnt_d < c_blank) || !bus.digit_en[idx_d] || w_lzb_dark[idx_d]) begin
            anode_d = '1;
        end else begin
            anode_d = ~(c_digit0 << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            pend_valid_q <= 1'b0;
            number_q     <= 4'h0;
            anode_q      <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_valid_q <= pend_valid_d;
            number_q     <= number_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.number     = number_q;
    assign bus.anode      = anode_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Directed self-checking bench for seg_scan_mux
//               (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_mux;
    logic clk;
    logic rst_n;
    int   k;
    int   n_checks;
    int   n_errs;

    seg_scan_mux_if #(.NUM_DIGITS(4)) ssm_if ();

    seg_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ssm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int t);
        while (k < t) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        ssm_if.value = v;
        ssm_if.load  = 1'b1;
        step();
        ssm_if.load  = 1'b0;
    endtask

    // Entered at cnt==0 of a slot; leaves at cnt==0 of the next slot.
    task automatic check_slot(input string tag, input logic [3:0] exp_num,
                              input logic [3:0] exp_an, input int exp_idx);
        check_eq({tag, "_idx"},   ssm_if.digit_idx, exp_idx);
        check_eq({tag, "_num0"},  ssm_if.number, exp_num);
        check_eq({tag, "_blank0"}, ssm_if.anode, 4'b1111);
        step();
        check_eq({tag, "_blank1"}, ssm_if.anode, 4'b1111);
        step();
        check_eq({tag, "_an2"},   ssm_if.anode, exp_an);
        check_eq({tag, "_num2"},  ssm_if.number, exp_num);
        repeat (5) step();
        check_eq({tag, "_an7"},   ssm_if.anode, exp_an);
        check_eq({tag, "_num7"},  ssm_if.number, exp_num);
        check_eq({tag, "_idx7"},  ssm_if.digit_idx, exp_idx);
        step();
    endtask

    initial begin
        logic [3:0] exp_an;
        logic       lzb;
`ifdef SEG_SCAN_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        n_checks = 0;
        n_errs   = 0;
        k        = 0;
        rst_n    = 1'b0;
        ssm_if.value    = '0;
        ssm_if.load     = 1'b0;
        ssm_if.digit_en = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_idx",   ssm_if.digit_idx, 0);
        check_eq("rst_num",   ssm_if.number, 0);
        check_eq("rst_anode", ssm_if.anode, 4'b1111);
        check_eq("rst_tick",  ssm_if.frame_tick, 0);
        rst_n = 1'b1;

        // Idle scan of zeros
        for (int j = 1; j <= 40; j++) begin
            step();
            exp_an = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << ((k / 8) % 4));
            if (lzb && ((k / 8) % 4) != 0) exp_an = 4'b1111;
            check_eq("idle_idx",   ssm_if.digit_idx, (k / 8) % 4);
            check_eq("idle_anode", ssm_if.anode, exp_an);
            check_eq("idle_tick",  ssm_if.frame_tick, (k % 32) == 0);
            check_eq("idle_num",   ssm_if.number, 0);
        end

        // Mid-frame load is held until the next boundary
        goto(44);
        do_load(16'h1234);
        goto(48); check_eq("pend_num_s2", ssm_if.number, 0);
        goto(63); check_eq("pend_num_s3", ssm_if.number, 0);
        check_eq("pend_tick_lo", ssm_if.frame_tick, 0);
        goto(64); check_eq("load_tick", ssm_if.frame_tick, 1);
        check_slot("f2s0", 4'h4, 4'b1110, 0);
        check_eq("load_tick_gone", ssm_if.frame_tick, 0);
        check_slot("f2s1", 4'h3, 4'b1101, 1);
        check_slot("f2s2", 4'h2, 4'b1011, 2);
        check_slot("f2s3", 4'h1, 4'b0111, 3);

        // Last load in a frame wins
        goto(100); do_load(16'hAAAA);
        goto(105); do_load(16'h5678);
        goto(110); check_eq("old_frame_num", ssm_if.number, 4'h3);
        goto(128);
        check_slot("f4s0", 4'h8, 4'b1110, 0);
        check_slot("f4s1", 4'h7, 4'b1101, 1);
        check_slot("f4s2", 4'h6, 4'b1011, 2);
        check_slot("f4s3", 4'h5, 4'b0111, 3);

        // Load on the boundary edge goes straight to the new frame
        goto(170); check_eq("pre_bnd_num", ssm_if.number, 4'h7);
        goto(191); do_load(16'h9ABC);
        check_eq("bnd_tick", ssm_if.frame_tick, 1);
        check_slot("f6s0", 4'hC, 4'b1110, 0);
        check_slot("f6s1", 4'hB, 4'b1101, 1);
        check_slot("f6s2", 4'hA, 4'b1011, 2);
        check_slot("f6s3", 4'h9, 4'b0111, 3);
        goto(226); check_eq("bnd_persist", ssm_if.number, 4'hC);

        // Per-digit enable
        goto(230); do_load(16'h1234);
        goto(250); ssm_if.digit_en = 4'b1010;
        goto(256);
        check_slot("en_s0", 4'h4, 4'b1111, 0);
        check_slot("en_s1", 4'h3, 4'b1101, 1);
        check_slot("en_s2", 4'h2, 4'b1111, 2);
        check_slot("en_s3", 4'h1, 4'b0111, 3);
        ssm_if.digit_en = 4'b1111;

        // Reset during slot 2 abandons the slot and clears active
        goto(306);
        check_eq("pre_rst_idx", ssm_if.digit_idx, 2);
        rst_n = 1'b0;
        step();
        check_eq("mrst_idx",   ssm_if.digit_idx, 0);
        check_eq("mrst_num",   ssm_if.number, 0);
        check_eq("mrst_anode", ssm_if.anode, 4'b1111);
        rst_n = 1'b1;
        k = 0;
        goto(8);  check_eq("mrst_restart_idx", ssm_if.digit_idx, 1);
        goto(34);
        check_eq("mrst_s0_an",  ssm_if.anode, 4'b1110);
        check_eq("mrst_s0_num", ssm_if.number, 0);
        goto(42);
        check_eq("mrst_s1_an",  ssm_if.anode, lzb ? 4'b1111 : 4'b1101);
        check_eq("mrst_s1_num", ssm_if.number, 0);

        // Leading zeros (dark only when blanking is built in)
        do_load(16'h0050);
        goto(64);
        check_slot("lz_s0", 4'h0, 4'b1110, 0);
        check_slot("lz_s1", 4'h5, 4'b1101, 1);
        check_slot("lz_s2", 4'h0, lzb ? 4'b1111 : 4'b1011, 2);
        check_slot("lz_s3", 4'h0, lzb ? 4'b1111 : 4'b0111, 3);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
